prml_read_ctrl: RTL
===================

PRML_READ_CTRL -- requirements
Module: prml_read_ctrl

Interface
REQ-001 Parameter SYNC_WORD, default 8'b1010_0001: sync mark hunted in decoded bitstream.
REQ-002 Parameter HUNT_TIMEOUT, default 64: max decoded bits in HUNT before abort.
REQ-003 Parameter ERR_LIMIT, default 4: decoder error count that forces abort.
REQ-004 clock  input  1  single clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a read frame.
REQ-007 frame_len  input  8  payload length in bytes, sampled on accepted start.
REQ-008 dec_bit  input  1  decoded bit from Viterbi decoder.
REQ-009 dec_valid  input  1  dec_bit/dec_error valid this cycle; the stream cannot be stalled.
REQ-010 dec_error  input  1  decoder illegal-transition flag, qualified by dec_valid.
REQ-011 dec_en  output  1  decoder enable, high in HUNT and DATA only.
REQ-012 byte_data  output  8  assembled payload byte, MSB first.
REQ-013 byte_valid  output  1  byte_data valid; held until accepted.
REQ-014 byte_ready  input  1  consumer accepts byte when byte_valid and byte_ready are both high.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse on successful frame completion.
REQ-017 abort  output  1  one-cycle pulse on frame abort.
REQ-018 status  output  2  00 ok, 01 sync timeout, 10 error limit, 11 overrun; held until next accepted start.
REQ-019 err_count  output  4  decoder errors in current frame, saturating at 15.

Function
REQ-020 States SHALL be IDLE, HUNT, DATA, FLUSH; done and abort pulse on the transition back to IDLE.
REQ-021 IDLE: start SHALL be accepted; on acceptance, latch frame_len, clear err_count, status, bit/byte counters and sync shifter; go to HUNT next cycle.
REQ-022 start SHALL be ignored whenever busy is high.
REQ-023 HUNT: each dec_valid SHALL shift dec_bit into an 8-bit shifter (LSB in) and increment the hunt bit counter.
REQ-024 HUNT: when the shifter, including the current bit, equals SYNC_WORD, go to DATA next cycle; if latched frame_len is 0, pulse done and go to IDLE instead.
REQ-025 HUNT: if HUNT_TIMEOUT bits are consumed without a match, pulse abort, set status 01, go to IDLE.
REQ-026 HUNT and DATA: dec_valid with dec_error SHALL increment err_count, saturating; on reaching ERR_LIMIT, pulse abort, set status 10, go to IDLE.
REQ-027 DATA: bits SHALL be assembled MSB first; on the 8th valid bit, byte_data and byte_valid SHALL be registered and visible the following cycle.
REQ-028 Overrun: if a byte completes while byte_valid is high and byte_ready is low, pulse abort, set status 11, go to IDLE; the pending byte is dropped.
REQ-029 A byte accepted in the same cycle a new byte completes SHALL NOT be an overrun.
REQ-030 After the frame_len-th byte completes, go to FLUSH; dec_en low; further dec_valid ignored.
REQ-031 FLUSH: on handshake of the final byte, pulse done with status 00 and go to IDLE.
REQ-032 Simultaneous error-limit and byte completion: abort wins; no byte_valid is raised.
REQ-033 Any abort SHALL clear byte_valid in the same cycle abort pulses.
REQ-034 dec_valid in IDLE or FLUSH SHALL have no effect on counters or err_count.

Reset
REQ-035 reset SHALL force IDLE, and dec_en, byte_valid, busy, done and abort to 0, byte_data 0, status 00, err_count 0, and all counters and the shifter to 0.
REQ-036 reset SHALL take priority over every other input, including during HUNT, DATA or FLUSH; no done or abort pulse is generated.

Verification
REQ-037 start, frame_len=2, bits 0011 then A1 then 0x5A, 0xC3, byte_ready=1 -> bytes 5A, C3; done pulse; status 00; err_count 0.
REQ-038 start, 64 bits all zero -> abort on the 64th bit; status 01; dec_en low next cycle.
REQ-039 start, sync seen, then 4 dec_valid with dec_error=1 during DATA -> abort on the 4th error; status 10; err_count 4.
REQ-040 frame_len=3, byte_ready=0 held -> abort when the 2nd byte completes; status 11; byte_valid drops.
REQ-041 start during DATA -> ignored; reset asserted mid-DATA -> all outputs 0 next cycle; no done or abort.
REQ-042 frame_len=0, sync matched -> done the cycle after the match; no byte_valid.

Source files
------------

// File: rtl/prml_read_ctrl_if.sv
// prml_read_ctrl_if: bundle of decoder stream, byte handshake and frame status signals for prml_read_ctrl
// master: frame requester / decoder / byte consumer side; slave: the read controller
interface prml_read_ctrl_if;
  logic       start;
  logic [7:0] frame_len;
  logic       dec_bit;
  logic       dec_valid;
  logic       dec_error;
  logic       dec_en;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       busy;
  logic       done;
  logic       abort;
  logic [1:0] status;
  logic [3:0] err_count;
  modport master (
    output start, frame_len, dec_bit, dec_valid, dec_error, byte_ready,
    input  dec_en, byte_data, byte_valid, busy, done, abort, status, err_count
  );
  modport slave (
    input  start, frame_len, dec_bit, dec_valid, dec_error, byte_ready,
    output dec_en, byte_data, byte_valid, busy, done, abort, status, err_count
  );
endinterface

// File: rtl/prml_read_ctrl.sv
// prml_read_ctrl: hunts a sync word in the decoded bitstream, then assembles frame_len payload bytes
// clock/reset: single clock, synchronous active-high reset; bus: prml_read_ctrl_if slave modport
module prml_read_ctrl #(
  parameter logic [7:0] SYNC_WORD    = 8'b1010_0001,
  parameter int         HUNT_TIMEOUT = 64,
  parameter int         ERR_LIMIT    = 4
) (
  input logic            clock,
  input logic            reset,
  prml_read_ctrl_if.slave bus
);
  localparam int HW = $clog2(HUNT_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, HUNT, DATA, FLUSH} state_t;
  state_t          state_q, state_d;
  logic [7:0]      len_q, len_d, shift_q, shift_d, byte_cnt_q, byte_cnt_d, byte_data_q, byte_data_d;
  logic [HW-1:0]   hunt_cnt_q, hunt_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [3:0]      err_q, err_d;
  logic [1:0]      status_q, status_d;
  logic            byte_valid_q, byte_valid_d, done_q, done_d, abort_q, abort_d;
  logic [7:0]      shift_nx;
  logic            bit_in, err_in, err_hit;
  always_comb begin
    bit_in       = bus.dec_valid && (state_q == HUNT || state_q == DATA);
    shift_nx     = {shift_q[6:0], bus.dec_bit};
    err_in       = bit_in && bus.dec_error;
    err_d        = (err_in && err_q != 4'hf) ? err_q + 4'd1 : err_q;
    err_hit      = err_in && (32'(err_d) >= 32'(ERR_LIMIT));
    state_d      = state_q;
    len_d        = len_q;
    shift_d      = bit_in ? shift_nx : shift_q;
    hunt_cnt_d   = hunt_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = byte_valid_q && !bus.byte_ready;
    status_d     = status_q;
    done_d       = 1'b0;
    abort_d      = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d    = HUNT;
        len_d      = bus.frame_len;
        err_d      = 4'd0;
        status_d   = 2'b00;
        shift_d    = 8'd0;
        hunt_cnt_d = '0;
        bit_cnt_d  = 3'd0;
        byte_cnt_d = 8'd0;
      end
      HUNT: if (bit_in) begin
        hunt_cnt_d = hunt_cnt_q + 1'b1;
        if (err_hit) begin
          state_d  = IDLE;
          abort_d  = 1'b1;
          status_d = 2'b10;
        end else if (shift_nx == SYNC_WORD) begin
          // an empty frame completes as soon as the sync mark is found
          state_d = (len_q == 8'd0) ? IDLE : DATA;
          done_d  = (len_q == 8'd0);
        end else if (hunt_cnt_d == HW'(HUNT_TIMEOUT)) begin
          state_d  = IDLE;
          abort_d  = 1'b1;
          status_d = 2'b01;
        end
      end
      DATA: if (bit_in) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (err_hit) begin
          state_d  = IDLE;
          abort_d  = 1'b1;
          status_d = 2'b10;
        end else if (bit_cnt_q == 3'd7) begin
          // a byte handed over this very cycle frees the output register
          if (byte_valid_q && !bus.byte_ready) begin
            state_d  = IDLE;
            abort_d  = 1'b1;
            status_d = 2'b11;
          end else begin
            byte_data_d  = shift_nx;
            byte_valid_d = 1'b1;
            byte_cnt_d   = byte_cnt_q + 8'd1;
            state_d      = (byte_cnt_d == len_q) ? FLUSH : DATA;
          end
        end
      end
      FLUSH: if (byte_valid_q && bus.byte_ready) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (abort_d) byte_valid_d = 1'b0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      len_q        <= 8'd0;
      shift_q      <= 8'd0;
      hunt_cnt_q   <= '0;
      bit_cnt_q    <= 3'd0;
      byte_cnt_q   <= 8'd0;
      byte_data_q  <= 8'd0;
      byte_valid_q <= 1'b0;
      err_q        <= 4'd0;
      status_q     <= 2'b00;
      done_q       <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      shift_q      <= shift_d;
      hunt_cnt_q   <= hunt_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      err_q        <= err_d;
      status_q     <= status_d;
      done_q       <= done_d;
      abort_q      <= abort_d;
    end
  end
  assign bus.dec_en     = state_q == HUNT || state_q == DATA;
  assign bus.busy       = state_q != IDLE;
  assign bus.byte_data  = byte_data_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.done       = done_q;
  assign bus.abort      = abort_q;
  assign bus.status     = status_q;
  assign bus.err_count  = err_q;
endmodule
